fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the sign-extend unit.
//  - Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
//  - Buffers returned instructions in a small FIFO and presents them downstream, with their PC, over valid/ready.
//  - Bits [25:0] of each presented instruction feed the sign-extend unit.
//  - Applies branch redirects whose offset is the already-shifted extended address from the sign-extend unit.
// PARAMETERS
//  ADDR_W    64  PC / address width
//  RESET_PC  0   PC loaded on reset
//  BUF_DEPTH 2   instruction FIFO entries (>=1, power of 2)
// PORTS
//  clk            in  1       clock, rising edge
//  rst_n          in  1       asynchronous reset, active-low
//  imem_req_valid out 1       fetch request valid
//  imem_req_ready in  1       memory accepts request
//  imem_req_addr  out ADDR_W  fetch address (= pc)
//  imem_rsp_valid in  1       response data valid (one per accepted request)
//  imem_rsp_data  in  32      fetched instruction word
//  inst_valid     out 1       FIFO head valid
//  inst_ready     in  1       downstream consumes head
//  inst           out 32      head instruction
//  inst_pc        out ADDR_W  PC of head instruction
//  br_taken       in  1       redirect strobe, one cycle
//  br_base        in  ADDR_W  PC of the branch instruction
//  br_offset      in  ADDR_W  sign-extended, <<2 offset
//  fetch_err      out 1       sticky misalign flag (macro only; else tied 0)
// BEHAVIOUR
//  - Reset: one clock, clk; asynchronous active-low reset, rst_n.
//    - Outputs: pc=RESET_PC, FIFO empty, inst_valid=0, imem_req_valid=0, fetch_err=0, state=IDLE.
//    - Asserting rst_n mid-transaction discards any outstanding response.
//  - States:
//    - IDLE: imem_req_valid=(count<BUF_DEPTH). Handshake -> WAIT, tag=pc, pc+=4.
//    - WAIT: req_valid=0. rsp_valid -> push {data,tag}, -> IDLE.
//    - DROP: req_valid=0. rsp_valid -> discard, -> IDLE.
//  - Outstanding requests: at most one. IDLE requests only when the FIFO has a free slot, so a push never finds the FIFO full.
//  - Request stability: imem_req_addr is stable while valid && !ready.
//  - Request latency: first request asserts the cycle after reset release.
//  - Response path: an instruction appears on inst_valid the cycle after its rsp_valid.
//  - FIFO: push and pop in the same cycle are both legal; count is unchanged. inst and inst_pc hold while inst_valid && !inst_ready.
//  - Redirect (br_taken=1):
//    - Target: target=br_base+br_offset, modulo 2^ADDR_W (wraps).
//    - Next edge: pc<=target, FIFO flushed (a same-cycle pop is ignored), inst_valid=0.
//    - WAIT -> DROP. An in-flight request handshake that same cycle also -> DROP.
//    - The target is fetched once back in IDLE.
//    - Redirect in DROP: pc updated, remain DROP.
//    - Redirect coincident with rsp_valid in WAIT: response dropped, -> IDLE.
//    - Redirect has priority over the pc+=4 increment.
//  - Arithmetic: pc+4 wraps at 2^ADDR_W. No alignment check without the macro.
// CONFIGURATION
//  - FETCH_MISALIGN_CHK_EN defined:
//    - A redirect with target[1:0]!=0 sets fetch_err next cycle.
//    - FIFO flushes and pc=target as usual, but no further requests issue until reset.
//    - fetch_err clears only on reset.
//  - Undefined: fetch_err tied 0; misaligned targets are fetched as given.
// TESTING
//  1 Reset, mem ready, 1-cycle rsp, inst_ready=1 -> addrs 0,4,8,... in order; inst_pc matches.
//  2 inst_ready=0 -> 2 instructions buffered; req_valid low; head 0x0; resume pops 0x0,0x4 in order.
//  3 br_taken br_base=0x10, br_offset=0xFFFF_FFFF_FFFF_FFF8 while WAIT -> stale rsp dropped; next req addr=0x8.
//  4 br_taken same cycle as rsp_valid and pop -> FIFO empty next cycle; next req addr=target.
//  5 br_base=0xFFFF_FFFF_FFFF_FFFC, br_offset=0x8 -> next req addr 0x4 (wrap).
//  6 MACRO: offset 0x2 -> fetch_err=1 next cycle, no request ever; rst_n low clears it.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word fetches and buffers returned words in a FIFO.
// Optional macro FETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect flag (fetch_err).
module fetch_unit #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_base,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              fetch_err
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, r_tag;
  logic                r_run;
  logic [CNT_W-1:0]    r_cnt;
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [31:0]         r_mem_inst [BUF_DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc   [BUF_DEPTH];

  logic [ADDR_W-1:0]   w_target;
  logic                w_req_valid, w_hs, w_push, w_pop, w_blk;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_target = br_base + br_offset;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (br_taken && (w_target[1:0] != 2'b00))
      r_err <= 1'b1;
  end
  assign w_blk     = r_err;
  assign fetch_err = r_err;
`else
  assign w_blk     = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // r_run delays the first request to the cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (br_taken)
        r_pc <= w_target;
      else if (w_hs)
        r_pc <= r_pc + ADDR_W'(4);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_valid = r_run && !w_blk && (r_cnt < CNT_W'(BUF_DEPTH));
        if (w_req_valid && imem_req_ready)
          w_state_nxt = br_taken ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_push      = !br_taken;
          w_state_nxt = S_IDLE;
        end else if (br_taken) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        // a redirect here only moves the PC; the stale response still has to be absorbed
        if (imem_rsp_valid)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hs  = w_req_valid && imem_req_ready;
  assign w_pop = (r_cnt != '0) && inst_ready && !br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (br_taken) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Data storage carries no reset; validity is tracked by r_cnt
  always_ff @(posedge clk) begin
    if (w_hs)
      r_tag <= r_pc;
    if (w_push) begin
      r_mem_inst[r_wptr] <= imem_rsp_data;
      r_mem_pc[r_wptr]   <= r_tag;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_cnt != '0);
  assign inst           = r_mem_inst[r_rptr];
  assign inst_pc        = r_mem_pc[r_rptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: per-cycle {inputs, expected outputs} vectors plus reset and redirect corner sequences.
module tb_fetch_unit;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        br_taken;
  logic [63:0] br_base, br_offset;
  logic        fetch_err;

  int n_chk = 0;
  int n_pass = 0;

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .br_taken(br_taken), .br_base(br_base), .br_offset(br_offset),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        irdy, br;
    logic [63:0] bbase, boff;
    logic        qv;
    logic [63:0] qaddr;
    logic        iv;
    logic [31:0] inst;
    logic [63:0] ipc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic irdy, input logic br, input logic [63:0] bbase,
                              input logic [63:0] boff, input logic qv, input logic [63:0] qaddr,
                              input logic iv, input logic [31:0] ins, input logic [63:0] ipc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.irdy = irdy; v.br = br;
    v.bbase = bbase; v.boff = boff; v.qv = qv; v.qaddr = qaddr;
    v.iv = iv; v.inst = ins; v.ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic irdy, input logic br, input logic [63:0] bbase,
                       input logic [63:0] boff);
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rdata;
    inst_ready = irdy; br_taken = br; br_base = bbase; br_offset = boff;
  endtask

  vec_t vecs [29];

  initial begin
    vecs[0]  = mk(1, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h0,   0, 32'h0,         64'h0);
    vecs[1]  = mk(0, 1, 32'hC000_0000, 1, 0, 64'h0, 64'h0, 0, 64'h4,   0, 32'h0,         64'h0);
    vecs[2]  = mk(1, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h4,   1, 32'hC000_0000, 64'h0);
    vecs[3]  = mk(0, 1, 32'hC000_0004, 1, 0, 64'h0, 64'h0, 0, 64'h8,   0, 32'h0,         64'h0);
    vecs[4]  = mk(1, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h8,   1, 32'hC000_0004, 64'h4);
    vecs[5]  = mk(0, 1, 32'hC000_0008, 0, 0, 64'h0, 64'h0, 0, 64'hC,   0, 32'h0,         64'h0);
    vecs[6]  = mk(1, 0, 32'h0,         0, 0, 64'h0, 64'h0, 1, 64'hC,   1, 32'hC000_0008, 64'h8);
    vecs[7]  = mk(0, 1, 32'hC000_000C, 0, 0, 64'h0, 64'h0, 0, 64'h10,  1, 32'hC000_0008, 64'h8);
    vecs[8]  = mk(1, 0, 32'h0,         0, 0, 64'h0, 64'h0, 0, 64'h10,  1, 32'hC000_0008, 64'h8);
    vecs[9]  = mk(0, 0, 32'h0,         1, 0, 64'h0, 64'h0, 0, 64'h10,  1, 32'hC000_0008, 64'h8);
    vecs[10] = mk(0, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h10,  1, 32'hC000_000C, 64'hC);
    vecs[11] = mk(0, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h10,  0, 32'h0,         64'h0);
    vecs[12] = mk(1, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h10,  0, 32'h0,         64'h0);
    vecs[13] = mk(0, 0, 32'h0,         1, 1, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h14, 0, 32'h0, 64'h0);
    vecs[14] = mk(0, 1, 32'hC000_0010, 1, 0, 64'h0, 64'h0, 0, 64'h8,   0, 32'h0,         64'h0);
    vecs[15] = mk(1, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h8,   0, 32'h0,         64'h0);
    vecs[16] = mk(0, 1, 32'hC000_0008, 0, 0, 64'h0, 64'h0, 0, 64'hC,   0, 32'h0,         64'h0);
    vecs[17] = mk(1, 0, 32'h0,         0, 0, 64'h0, 64'h0, 1, 64'hC,   1, 32'hC000_0008, 64'h8);
    vecs[18] = mk(0, 1, 32'hC000_000C, 1, 1, 64'h40, 64'h20, 0, 64'h10, 1, 32'hC000_0008, 64'h8);
    vecs[19] = mk(1, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h60,  0, 32'h0,         64'h0);
    vecs[20] = mk(0, 1, 32'hC000_0060, 1, 0, 64'h0, 64'h0, 0, 64'h64,  0, 32'h0,         64'h0);
    vecs[21] = mk(0, 0, 32'h0,         1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1, 64'h64, 1, 32'hC000_0060, 64'h60);
    vecs[22] = mk(1, 0, 32'h0,         1, 1, 64'h100, 64'h0, 1, 64'h4,   0, 32'h0,       64'h0);
    vecs[23] = mk(0, 0, 32'h0,         1, 1, 64'h200, 64'h0, 0, 64'h100, 0, 32'h0,       64'h0);
    vecs[24] = mk(0, 1, 32'hC000_0004, 1, 0, 64'h0, 64'h0, 0, 64'h200, 0, 32'h0,         64'h0);
    vecs[25] = mk(1, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h200, 0, 32'h0,         64'h0);
    vecs[26] = mk(0, 1, 32'hC000_0200, 1, 0, 64'h0, 64'h0, 0, 64'h204, 0, 32'h0,         64'h0);
    vecs[27] = mk(0, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h204, 1, 32'hC000_0200, 64'h200);
    vecs[28] = mk(0, 0, 32'h0,         1, 0, 64'h0, 64'h0, 1, 64'h204, 0, 32'h0,         64'h0);

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 64'h0, 64'h0);
    repeat (2) @(negedge clk);
    chk("rst.req_valid",  {63'h0, imem_req_valid}, 64'h0);
    chk("rst.req_addr",   imem_req_addr, 64'h0);
    chk("rst.inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst.fetch_err",  {63'h0, fetch_err}, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("release.req_valid", {63'h0, imem_req_valid}, 64'h0);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d.req_valid", i), {63'h0, imem_req_valid}, {63'h0, vecs[i].qv});
      chk($sformatf("v%0d.req_addr", i), imem_req_addr, vecs[i].qaddr);
      chk($sformatf("v%0d.inst_valid", i), {63'h0, inst_valid}, {63'h0, vecs[i].iv});
      chk($sformatf("v%0d.fetch_err", i), {63'h0, fetch_err}, 64'h0);
      if (vecs[i].iv) begin
        chk($sformatf("v%0d.inst", i), {32'h0, inst}, {32'h0, vecs[i].inst});
        chk($sformatf("v%0d.inst_pc", i), inst_pc, vecs[i].ipc);
      end
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].irdy,
            vecs[i].br, vecs[i].bbase, vecs[i].boff);
    end

    // Reset asserted while a request is outstanding; the late response must be ignored
    @(negedge clk);
    drive(1, 0, 32'h0, 1, 0, 64'h0, 64'h0);
    @(negedge clk);
    chk("midrst.pre_req_valid", {63'h0, imem_req_valid}, 64'h0);
    drive(0, 0, 32'h0, 1, 0, 64'h0, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.req_addr",   imem_req_addr, 64'h0);
    chk("midrst.inst_valid", {63'h0, inst_valid}, 64'h0);
    @(negedge clk);
    drive(0, 1, 32'hDEAD_BEEF, 1, 0, 64'h0, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("midrst.release_req_valid", {63'h0, imem_req_valid}, 64'h0);
    @(negedge clk);
    chk("midrst.first_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("midrst.first_req_addr",  imem_req_addr, 64'h0);
    chk("midrst.stale_dropped",   {63'h0, inst_valid}, 64'h0);

    // Redirect to a misaligned target
    drive(0, 0, 32'h0, 1, 1, 64'h0, 64'h2);
    @(negedge clk);
    drive(1, 0, 32'h0, 1, 0, 64'h0, 64'h0);
    chk("mis.req_addr", imem_req_addr, 64'h2);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis.fetch_err", {63'h0, fetch_err}, 64'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mis.no_req%0d", k), {63'h0, imem_req_valid}, 64'h0);
      @(negedge clk);
    end
    chk("mis.err_sticky", {63'h0, fetch_err}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mis.err_cleared", {63'h0, fetch_err}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    chk("mis.fetch_err", {63'h0, fetch_err}, 64'h0);
    chk("mis.req_valid", {63'h0, imem_req_valid}, 64'h1);
    @(negedge clk);
    chk("mis.next_addr", imem_req_addr, 64'h6);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
